my_adder_core: RTL and testbench
================================

// Module: my_adder_core
//
// PURPOSE
//   Registered unsigned adder with carry-out. Each clock edge it captures the
//   sum of operands a and b, plus the carry. It is the core behind the
//   adder_if bus.
//   The clock comes from clk_if. All other signals go through adder_if.
//   The block is a leaf datapath: no internal state beyond its pipeline
//   registers.
//
// PARAMETERS
//   WIDTH       8   operand and sum width in bits (legal range >= 1)
//   REG_INPUTS  0   0: a/b feed the adder directly (latency 1);
//                   1: a/b/in_valid go through an extra input register stage
//                      (latency 2)
//
// PORTS
//   clk        in   1      single clock; all registers update on its rising edge
//   rstn       in   1      asynchronous reset, ACTIVE-HIGH despite its name
//                          (1 = in reset)
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   in_valid   in   1      qualifies a/b; tied high when unused
//   sum        out  WIDTH  registered low WIDTH bits of a+b
//   carry      out  1      registered bit WIDTH of a+b (unsigned carry-out)
//   out_valid  out  1      in_valid delayed by the pipeline latency
//
// BEHAVIOUR
//   - Reset: when rstn=1, sum, carry and out_valid go to 0 immediately, with
//     no clock needed.
//     - The input stage registers (REG_INPUTS=1) also clear to 0.
//     - Outputs stay 0 while rstn=1.
//     - On the first rising edge after rstn falls, a normal capture occurs.
//   - Arithmetic: {carry,sum} = zero-extended a + zero-extended b, computed
//     at WIDTH+1 bits.
//     - No saturation, no signed interpretation.
//     - Wrap-around appears only through carry=1 and the truncated sum.
//   - Latency:
//     - REG_INPUTS=0: operands present before edge N appear on sum/carry
//       after edge N.
//     - REG_INPUTS=1: they appear after edge N+1.
//     - Throughput is one result per cycle. Back-to-back operands are each
//       reflected exactly once, in order.
//   - Valid handling:
//     - sum/carry register every cycle regardless of in_valid, so the bus
//       monitor may sample unconditionally.
//     - out_valid tracks in_valid through the same number of stages, so
//       out_valid=1 marks a result that came from qualified operands.
//   - Hold: if a/b stay constant, sum/carry stay constant. There are no
//     spurious toggles.
//   - Reset mid-operation: in-flight results are discarded. Nothing captured
//     before reset assertion appears after release.
//   - X on a or b propagates to sum/carry only. out_valid depends solely on
//     in_valid and rstn.
//   - No combinational path from inputs to outputs.
//
// TESTING
//   - Reset: rstn=1 with a=0x12, b=0x34 toggling, clock running
//     -> sum=0x00, carry=0, out_valid=0 throughout.
//     Asserting rstn between edges clears outputs at once.
//   - Basic add (WIDTH=8, REG_INPUTS=0): a=0x10, b=0x20, in_valid=1
//     -> one edge later sum=0x30, carry=0, out_valid=1.
//   - Carry boundaries:
//     - 0xFF+0x01 -> sum=0x00, carry=1
//     - 0xFF+0xFF -> sum=0xFE, carry=1
//     - 0x80+0x7F -> sum=0xFF, carry=0
//     - 0x00+0x00 -> sum=0x00, carry=0
//   - Back-to-back stream: drive 0x01+0x01, 0x7F+0x01, 0xF0+0x20 on
//     consecutive edges -> outputs 0x02/0, 0x80/0, 0x10/1 on consecutive
//     edges.
//     With REG_INPUTS=1, the same sequence appears one cycle later.
//   - Reset mid-stream: pulse rstn=1 for a half cycle while 0xAA+0x55 is in
//     flight -> outputs 0 immediately.
//     The first post-release edge with a=0x03, b=0x04 gives sum=0x07.
//   - Randomized: 1000 random a/b/in_valid with a scoreboard comparing
//     {carry,sum} to a+b, delayed by the latency -> zero mismatches.
//     out_valid must equal the delayed in_valid.

Source files
------------

// File: rtl/my_adder_core.sv
// -----------------------------------------------------------------------------
// my_adder_core
//
// Registered unsigned adder with carry-out. This is the datapath behind the
// adder bus. Every rising clock edge it captures the full (WIDTH+1)-bit sum of
// a and b. sum/carry are registered on every cycle. out_valid carries in_valid
// through the same number of register stages, so a bus monitor can sample the
// result unconditionally and still tell which results were qualified.
//
// Parameters
//   WIDTH       operand and sum width in bits (>= 1)
//   REG_INPUTS  0: a/b/in_valid feed the adder directly (latency 1)
//               1: a/b/in_valid pass through an input register stage first
//                  (latency 2)
//
// Ports
//   clk        in   1      rising-edge clock for all registers
//   rstn       in   1      asynchronous reset, ACTIVE-HIGH despite the name
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   in_valid   in   1      qualifies a/b (tie high when unused)
//   sum        out  WIDTH  registered low WIDTH bits of a+b
//   carry      out  1      registered bit WIDTH of a+b
//   out_valid  out  1      in_valid delayed by the pipeline latency
// -----------------------------------------------------------------------------
module my_adder_core #(
  parameter int          WIDTH      = 8,
  parameter int unsigned REG_INPUTS = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  // Operands and qualifier as seen by the adder. They come either straight
  // from the ports or from the optional input register stage.
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_valid;

  // Full-precision sum. Both operands are zero-extended, so bit WIDTH is the
  // unsigned carry-out and no signed interpretation is involved.
  logic [WIDTH:0]   sum_full;

  generate
    if (REG_INPUTS != 0) begin : g_input_reg
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic             valid_q;

      // Input register stage. It clears together with the output stage, so a
      // reset pulse discards operands that are still in flight here. Without
      // that, a stale operand could show up on the outputs after release.
      always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
          a_q     <= '0;
          b_q     <= '0;
          valid_q <= 1'b0;
        end else begin
          a_q     <= a;
          b_q     <= b;
          valid_q <= in_valid;
        end
      end

      assign add_a     = a_q;
      assign add_b     = b_q;
      assign add_valid = valid_q;
    end else begin : g_input_direct
      assign add_a     = a;
      assign add_b     = b;
      assign add_valid = in_valid;
    end
  endgenerate

  assign sum_full = {1'b0, add_a} + {1'b0, add_b};

  // Output stage. sum/carry load on every edge whatever add_valid is. Because
  // the register always captures, constant operands give constant outputs and
  // nothing toggles spuriously. out_valid depends only on the qualifier path
  // and reset, so unknown operand bits can never corrupt it.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      sum       <= sum_full[WIDTH-1:0];
      carry     <= sum_full[WIDTH];
      out_valid <= add_valid;
    end
  end

endmodule

// File: tb/tb_my_adder_core.sv
// -----------------------------------------------------------------------------
// tb_my_adder_core
//
// Drives one shared stimulus stream into two instances of my_adder_core:
//   - dut0 with REG_INPUTS=0
//   - dut1 with REG_INPUTS=1
// A reference model records the arithmetic sum of every operand pair accepted
// on a clock edge. The expected output of each instance is the entry recorded
// latency-1 edges ago. A reset empties the recorded history.
// -----------------------------------------------------------------------------
module tb_my_adder_core;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rstn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             in_valid;

  logic [WIDTH-1:0] sum0, sum1;
  logic             carry0, carry1;
  logic             out_valid0, out_valid1;

  int checks   = 0;
  int failures = 0;

  // History of results accepted on clock edges.
  // Index 0 holds the newest entry (the result due from dut0). Index 1 holds
  // the one before it (the result due from dut1).
  logic [WIDTH:0] hist_sum [2];
  logic           hist_valid [2];

  // Directed carry-boundary table.
  logic [WIDTH-1:0] dir_a   [4];
  logic [WIDTH-1:0] dir_b   [4];
  logic [WIDTH:0]   dir_exp [4];

  // Back-to-back stream table.
  logic [WIDTH-1:0] str_a   [3];
  logic [WIDTH-1:0] str_b   [3];
  logic [WIDTH:0]   str_exp [3];

  always #5 clk = ~clk;

  my_adder_core #(.WIDTH(WIDTH), .REG_INPUTS(0)) dut0 (
    .clk       (clk),
    .rstn      (rstn),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum0),
    .carry     (carry0),
    .out_valid (out_valid0)
  );

  my_adder_core #(.WIDTH(WIDTH), .REG_INPUTS(1)) dut1 (
    .clk       (clk),
    .rstn      (rstn),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum1),
    .carry     (carry1),
    .out_valid (out_valid1)
  );

  // Empty the reference history, as a reset does to the pipeline.
  task automatic modelClear();
    for (int i = 0; i < 2; i++) begin
      hist_sum[i]   = '0;
      hist_valid[i] = 1'b0;
    end
  endtask

  // Present one operand set and let one rising edge take it. The model is
  // updated for that edge. Control returns 1 time unit after the edge, where
  // outputs are sampled and the next inputs are driven.
  task automatic applyStimulus(input logic [WIDTH-1:0] sa,
                               input logic [WIDTH-1:0] sb,
                               input logic             sv);
    a        = sa;
    b        = sb;
    in_valid = sv;
    @(posedge clk);
    if (rstn) begin
      modelClear();
    end else begin
      hist_sum[1]   = hist_sum[0];
      hist_valid[1] = hist_valid[0];
      hist_sum[0]   = {1'b0, sa} + {1'b0, sb};
      hist_valid[0] = sv;
    end
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkValue(input string          tag,
                            input logic [WIDTH:0] obs,
                            input logic [WIDTH:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare both instances against the reference model.
  task automatic checkOutput(input string tag);
    checkValue({tag, " lat1 carry/sum"}, {carry0, sum0}, hist_sum[0]);
    checkValue({tag, " lat1 valid"}, {{WIDTH{1'b0}}, out_valid0},
               {{WIDTH{1'b0}}, hist_valid[0]});
    checkValue({tag, " lat2 carry/sum"}, {carry1, sum1}, hist_sum[1]);
    checkValue({tag, " lat2 valid"}, {{WIDTH{1'b0}}, out_valid1},
               {{WIDTH{1'b0}}, hist_valid[1]});
  endtask

  initial begin
    dir_a[0] = 8'hFF; dir_b[0] = 8'h01; dir_exp[0] = 9'h100;
    dir_a[1] = 8'hFF; dir_b[1] = 8'hFF; dir_exp[1] = 9'h1FE;
    dir_a[2] = 8'h80; dir_b[2] = 8'h7F; dir_exp[2] = 9'h0FF;
    dir_a[3] = 8'h00; dir_b[3] = 8'h00; dir_exp[3] = 9'h000;

    str_a[0] = 8'h01; str_b[0] = 8'h01; str_exp[0] = 9'h002;
    str_a[1] = 8'h7F; str_b[1] = 8'h01; str_exp[1] = 9'h080;
    str_a[2] = 8'hF0; str_b[2] = 8'h20; str_exp[2] = 9'h110;

    $display("[TB] start");
    rstn     = 1'b1;
    a        = '0;
    b        = '0;
    in_valid = 1'b0;
    modelClear();

    // Hold reset with the clock running and the operands toggling.
    for (int i = 0; i < 4; i++) begin
      applyStimulus((i % 2 == 0) ? 8'h12 : 8'h34,
                    (i % 2 == 0) ? 8'h34 : 8'h12, 1'b1);
      checkOutput("reset hold");
      checkValue("reset hold sum0", {out_valid0, sum0}, 9'h000);
    end

    // Release reset between edges. The first edge after it captures normally.
    rstn = 1'b0;
    applyStimulus(8'h10, 8'h20, 1'b1);
    checkOutput("basic add");
    checkValue("basic add const", {carry0, sum0}, 9'h030);
    checkValue("basic add valid", {8'h00, out_valid0}, 9'h001);

    // Carry boundaries.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(dir_a[i], dir_b[i], 1'b1);
      checkOutput($sformatf("boundary %0d", i));
      checkValue($sformatf("boundary %0d const", i), {carry0, sum0}, dir_exp[i]);
    end

    // Back-to-back stream on consecutive edges. dut1 trails dut0 by one edge.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(str_a[i], str_b[i], 1'b1);
      checkOutput($sformatf("stream %0d", i));
      checkValue($sformatf("stream %0d const lat1", i), {carry0, sum0}, str_exp[i]);
      if (i > 0)
        checkValue($sformatf("stream %0d const lat2", i), {carry1, sum1}, str_exp[i-1]);
    end
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("stream flush");
    checkValue("stream flush const lat2", {carry1, sum1}, str_exp[2]);
    checkValue("stream flush valid lat1", {8'h00, out_valid0}, 9'h000);

    // Constant operands must give constant outputs.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h5A, 8'h3C, 1'b1);
      checkOutput("hold");
      checkValue("hold const", {carry0, sum0}, 9'h096);
    end

    // Reset mid-stream: AA+55 is in flight and sits in dut1's input stage.
    applyStimulus(8'hAA, 8'h55, 1'b1);
    checkOutput("pre mid reset");
    rstn = 1'b1;
    #1;
    modelClear();
    checkOutput("mid reset async clear");
    checkValue("mid reset const", {carry0, sum0}, 9'h000);
    #2;
    rstn = 1'b0;
    applyStimulus(8'h03, 8'h04, 1'b1);
    checkOutput("post release");
    checkValue("post release const", {carry0, sum0}, 9'h007);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("post release drain");
    checkValue("post release const lat2", {carry1, sum1}, 9'h007);

    // Randomized stream against the reference model.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)));
      checkOutput($sformatf("random %0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
